// File: rtl/fp_addsub_seq_if.sv
// Operand/result bus for fp_addsub_seq: packed {op1,op2} operands, registered result side.
// Flag signals exist only when FP_FLAGS_EN is defined.
interface fp_addsub_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
);
    logic               load;
    logic               op;
    logic [2*EXP_W-1:0] exps;
    logic [2*MAN_W-1:0] mans;
    logic               busy;
    logic               done;
    logic [EXP_W-1:0]   result_exp;
    logic [MAN_W-1:0]   result_man;
    logic               result_sign;
`ifdef FP_FLAGS_EN
    logic               flag_ovf;
    logic               flag_unf;
    logic               flag_zero;

    modport master (output load, op, exps, mans,
                    input  busy, done, result_exp, result_man, result_sign,
                           flag_ovf, flag_unf, flag_zero);
    modport slave  (input  load, op, exps, mans,
                    output busy, done, result_exp, result_man, result_sign,
                           flag_ovf, flag_unf, flag_zero);
`else
    modport master (output load, op, exps, mans,
                    input  busy, done, result_exp, result_man, result_sign);
    modport slave  (input  load, op, exps, mans,
                    output busy, done, result_exp, result_man, result_sign);
`endif
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP add/sub sequencer: bit-serial alignment and normalization.
// Optional status flags (ovf/unf/zero) enabled by defining FP_FLAGS_EN.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input logic            clk,
    input logic            reset,
    fp_addsub_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, COMPUTE, NORM, DONE} state_t;

    localparam logic [EXP_W-1:0] E_MAX = '1;

    state_t           state;
    logic [EXP_W-1:0] e, d;
    logic [MAN_W-1:0] x, y;
    logic             shift_x;
    logic             op_sub;
    logic [MAN_W:0]   s;
    logic             sign;

    logic [EXP_W-1:0] exp1, exp2, e_max, diff;
    logic [MAN_W-1:0] man1, man2;
    logic             exp2_larger, diff_big, accept;

    assign {exp1, exp2} = bus.exps;
    assign {man1, man2} = bus.mans;
    assign exp2_larger  = exp1 < exp2;
    assign e_max        = exp2_larger ? exp2 : exp1;
    assign diff         = exp2_larger ? (exp2 - exp1) : (exp1 - exp2);
    assign diff_big     = 32'(diff) >= 32'(MAN_W + 1);
    assign accept       = bus.load && (state == IDLE || state == DONE);

    // One normalization step: either a shift (fin=0) or the final result (fin=1).
    logic             fin;
    logic [EXP_W-1:0] fin_exp, next_e;
    logic [MAN_W-1:0] fin_man;
    logic             fin_sign;
    logic [MAN_W:0]   next_s;
`ifdef FP_FLAGS_EN
    logic             fin_ovf, fin_unf, fin_zero;
`endif

    always_comb begin
        fin      = 1'b0;
        fin_exp  = e;
        fin_man  = s[MAN_W-1:0];
        fin_sign = sign;
        next_s   = s;
        next_e   = e;
`ifdef FP_FLAGS_EN
        fin_ovf  = 1'b0;
        fin_unf  = 1'b0;
        fin_zero = 1'b0;
`endif
        if (s[MAN_W]) begin
            if (e == E_MAX) begin
                fin     = 1'b1;
                fin_man = '1;
`ifdef FP_FLAGS_EN
                fin_ovf = 1'b1;
`endif
            end else begin
                next_s = s >> 1;
                next_e = e + EXP_W'(1);
            end
        end else if (s == '0) begin
            fin      = 1'b1;
            fin_exp  = '0;
            fin_sign = 1'b0;
`ifdef FP_FLAGS_EN
            fin_zero = 1'b1;
`endif
        end else if (e == '0) begin
            fin = 1'b1;
`ifdef FP_FLAGS_EN
            fin_unf = 1'b1;
`endif
        end else if (!s[MAN_W-1]) begin
            next_s = s << 1;
            next_e = e - EXP_W'(1);
        end else begin
            fin = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            e               <= '0;
            d               <= '0;
            x               <= '0;
            y               <= '0;
            shift_x         <= 1'b0;
            op_sub          <= 1'b0;
            s               <= '0;
            sign            <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result_exp  <= '0;
            bus.result_man  <= '0;
            bus.result_sign <= 1'b0;
`ifdef FP_FLAGS_EN
            bus.flag_ovf    <= 1'b0;
            bus.flag_unf    <= 1'b0;
            bus.flag_zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (accept) begin
                        e        <= e_max;
                        op_sub   <= bus.op;
                        x        <= man1;
                        y        <= man2;
                        shift_x  <= exp2_larger;
                        bus.busy <= 1'b1;
                        if (diff == '0) begin
                            state <= COMPUTE;
                        end else if (diff_big) begin
                            // Smaller operand lies entirely below the LSB: drop it without shifting.
                            if (exp2_larger) x <= '0;
                            else             y <= '0;
                            state <= COMPUTE;
                        end else begin
                            d     <= diff;
                            state <= ALIGN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ALIGN: begin
                    if (shift_x) x <= x >> 1;
                    else         y <= y >> 1;
                    d <= d - EXP_W'(1);
                    if (d == EXP_W'(1)) state <= COMPUTE;
                end
                COMPUTE: begin
                    if (!op_sub) begin
                        s    <= {1'b0, x} + {1'b0, y};
                        sign <= 1'b0;
                    end else if (x >= y) begin
                        s    <= {1'b0, x} - {1'b0, y};
                        sign <= 1'b0;
                    end else begin
                        s    <= {1'b0, y} - {1'b0, x};
                        sign <= 1'b1;
                    end
                    state <= NORM;
                end
                NORM: begin
                    if (fin) begin
                        bus.result_exp  <= fin_exp;
                        bus.result_man  <= fin_man;
                        bus.result_sign <= fin_sign;
`ifdef FP_FLAGS_EN
                        bus.flag_ovf    <= fin_ovf;
                        bus.flag_unf    <= fin_unf;
                        bus.flag_zero   <= fin_zero;
`endif
                        sign     <= fin_sign;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        s <= next_s;
                        e <= next_e;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: directed table, random ops vs arithmetic model,
// and hand-written busy-load / back-to-back / mid-operation reset sequences.
module tb_fp_addsub_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fp_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
    fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       op;
        logic [7:0] e1, e2;
        logic [23:0] m1, m2;
        logic [7:0] re;
        logic [23:0] rm;
        logic       rs, ovf, unf, zero;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: align by one wide shift, exact integer add/sub, then normalize by rule.
    function automatic void model(input logic op, input logic [7:0] e1, e2,
                                  input logic [23:0] m1, m2,
                                  output logic [7:0] re, output logic [23:0] rm,
                                  output logic rs, ovf, unf, zero, output int lat);
        longint x = m1, y = m2, s, top = 64'd1 << MAN_W;
        int ee, dd, k = 0;
        ovf = 0; unf = 0; zero = 0;
        if (e1 >= e2) begin ee = e1; dd = e1 - e2; end
        else          begin ee = e2; dd = e2 - e1; end
        if (dd >= MAN_W + 1) begin
            if (e1 >= e2) y = 0; else x = 0;
            dd = 0;
        end else if (e1 >= e2) y = y >> dd;
        else                   x = x >> dd;
        rs = op && (y > x);
        s  = !op ? x + y : (x >= y ? x - y : y - x);
        forever begin
            if (s >= top) begin
                if (ee == 255) begin ovf = 1; s = top - 1; break; end
                s = s >> 1; ee++; k++;
            end else if (s == 0) begin
                ee = 0; rs = 0; zero = 1; break;
            end else if (ee == 0) begin
                unf = 1; break;
            end else if (s < top / 2) begin
                s = s << 1; ee--; k++;
            end else break;
        end
        re  = 8'(ee);
        rm  = 24'(s);
        lat = dd + k + 2;
    endfunction

    task automatic start_op(input logic op, input logic [7:0] e1, e2, input logic [23:0] m1, m2);
        @(negedge clk);
        bus.load = 1'b1; bus.op = op; bus.exps = {e1, e2}; bus.mans = {m1, m2};
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done) break;
        end
        if (!bus.done) chk({tag, " done timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_check(input string tag, input vec_t v);
        int l;
        start_op(v.op, v.e1, v.e2, v.m1, v.m2);
        chk({tag, " busy"}, 64'(bus.busy), 64'd1);
        wait_done(tag, l);
        chk({tag, " latency"}, 64'(l), 64'(v.lat));
        chk({tag, " exp"}, 64'(bus.result_exp), 64'(v.re));
        chk({tag, " man"}, 64'(bus.result_man), 64'(v.rm));
        chk({tag, " sign"}, 64'(bus.result_sign), 64'(v.rs));
`ifdef FP_FLAGS_EN
        chk({tag, " flags"}, 64'({bus.flag_ovf, bus.flag_unf, bus.flag_zero}),
            64'({v.ovf, v.unf, v.zero}));
`endif
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 64'({bus.done, bus.busy}), 64'd0);
        chk({tag, " held exp"}, 64'(bus.result_exp), 64'(v.re));
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        int l, pulses;
        bus.load = 1'b0; bus.op = 1'b0; bus.exps = '0; bus.mans = '0;
        #2 reset = 1'b0;
        #5;
        chk("reset outputs", 64'({bus.busy, bus.done, bus.result_sign, bus.result_exp, bus.result_man}), 64'd0);
        @(negedge clk); reset = 1'b1;

        //        op  e1     e2     m1          m2          re     rm          rs ovf unf zero lat
        tbl.push_back('{0, 8'h7C, 8'h7B, 24'h6B851E, 24'h0CCCCD, 8'h7B, 24'hE3D708, 0, 0, 0, 0, 4});
        tbl.push_back('{0, 8'h80, 8'h80, 24'hC00000, 24'hC00000, 8'h81, 24'hC00000, 0, 0, 0, 0, 3});
        tbl.push_back('{1, 8'h80, 8'h80, 24'h800000, 24'hC00000, 8'h7F, 24'h800000, 1, 0, 0, 0, 3});
        tbl.push_back('{1, 8'h80, 8'h80, 24'hC00000, 24'hC00000, 8'h00, 24'h000000, 0, 0, 0, 1, 2});
        tbl.push_back('{0, 8'hFF, 8'hFF, 24'h800000, 24'h800000, 8'hFF, 24'hFFFFFF, 0, 1, 0, 0, 2});
        tbl.push_back('{0, 8'h9E, 8'h80, 24'h800000, 24'hFFFFFF, 8'h9E, 24'h800000, 0, 0, 0, 0, 2});
        tbl.push_back('{0, 8'h80, 8'h99, 24'hFFFFFF, 24'h800000, 8'h99, 24'h800000, 0, 0, 0, 0, 2});
        tbl.push_back('{0, 8'h98, 8'h80, 24'h800000, 24'hFFFFFF, 8'h98, 24'h800000, 0, 0, 0, 0, 26});
        tbl.push_back('{1, 8'h01, 8'h01, 24'h800000, 24'h7FFFFF, 8'h00, 24'h000002, 0, 0, 1, 0, 3});
        foreach (tbl[i]) run_check($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 150; i++) begin
            v.op = 1'($urandom_range(0, 1));
            v.e1 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 1) ? 254 + $urandom_range(0, 1)
                                                                          : $urandom_range(0, 1))
                                               : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       v.e2 = v.e1;
                1:       v.e2 = v.e1 ^ 8'($urandom_range(0, 31));
                2:       v.e2 = 8'($urandom_range(0, 255));
                default: v.e2 = v.e1 ^ 8'd1;
            endcase
            v.m1 = 24'($urandom);
            v.m2 = 24'($urandom);
            if ($urandom_range(0, 3) != 0) v.m1[23] = 1'b1;
            if ($urandom_range(0, 3) != 0) v.m2[23] = 1'b1;
            if ($urandom_range(0, 9) == 0) v.m2 = v.m1;
            if ($urandom_range(0, 1)) begin
                vec_t w = v;
                w.e1 = v.e2; w.e2 = v.e1; w.m1 = v.m2; w.m2 = v.m1;
                v = w;
            end
            model(v.op, v.e1, v.e2, v.m1, v.m2, v.re, v.rm, v.rs, v.ovf, v.unf, v.zero, v.lat);
            run_check($sformatf("rand%0d", i), v);
        end

        // load while busy is ignored
        start_op(0, 8'h7C, 8'h7B, 24'h6B851E, 24'h0CCCCD);
        @(posedge clk); #1;
        bus.load = 1'b1; bus.exps = {8'h80, 8'h80}; bus.mans = {24'hC00000, 24'hC00000};
        @(posedge clk); #1;
        bus.load = 1'b0;
        wait_done("busy-load", l);
        chk("busy-load latency", 64'(l + 2), 64'd4);
        chk("busy-load result", 64'({bus.result_sign, bus.result_exp, bus.result_man}), 64'({1'b0, 8'h7B, 24'hE3D708}));
        @(posedge clk); #1;
        chk("busy-load idle", 64'({bus.busy, bus.done}), 64'd0);

        // back-to-back: second load presented during the DONE cycle
        start_op(0, 8'h80, 8'h80, 24'hC00000, 24'hC00000);
        wait_done("b2b first", l);
        chk("b2b first latency", 64'(l), 64'd3);
        bus.load = 1'b1; bus.op = 1'b1; bus.exps = {8'h80, 8'h80}; bus.mans = {24'h800000, 24'hC00000};
        @(posedge clk); #1;
        bus.load = 1'b0;
        chk("b2b accepted", 64'({bus.busy, bus.done}), 64'b10);
        chk("b2b held", 64'({bus.result_exp, bus.result_man}), 64'({8'h81, 24'hC00000}));
        wait_done("b2b second", l);
        chk("b2b second latency", 64'(l), 64'd3);
        chk("b2b second result", 64'({bus.result_sign, bus.result_exp, bus.result_man}), 64'({1'b1, 8'h7F, 24'h800000}));

        // reset in ALIGN aborts immediately, no later done
        start_op(0, 8'h98, 8'h80, 24'h800000, 24'hFFFFFF);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort outputs", 64'({bus.busy, bus.done, bus.result_sign, bus.result_exp, bus.result_man}), 64'd0);
        @(negedge clk); reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) pulses++;
        end
        chk("abort no done", 64'(pulses), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
